// File: rtl/rand_range_pkg.sv
// rtl/rand_range_pkg.sv - shared width, state encoding and limit-to-width helper for rand_range
package rand_pkg;

  localparam int RND_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Smallest w with 2^w >= limit; limit 0 stands for 256 (w=8), limit 1 gives w=0.
  function automatic logic [3:0] limit_to_width(input logic [RND_W-1:0] limit);
    logic [3:0] w;
    w = 4'd0;
    if (limit == '0) begin
      w = 4'(RND_W);
    end else begin
      for (int i = 0; i < RND_W; i++) begin
        if ((9'd1 << i) < {1'b0, limit}) w = 4'(i + 1);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rand_range_if.sv
// rtl/rand_range_if.sv - request/response handshake bundle for rand_range
interface rand_range_if;
  import rand_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [RND_W-1:0] req_limit;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [RND_W-1:0] rsp_value;
  logic             rsp_fallback;

  // Requester / consumer side
  modport master (
    output req_valid, req_limit, rsp_ready,
    input  req_ready, rsp_valid, rsp_value, rsp_fallback
  );

  // rand_range side
  modport slave (
    input  req_valid, req_limit, rsp_ready,
    output req_ready, rsp_valid, rsp_value, rsp_fallback
  );

endinterface

// File: rtl/rand_range_width_lut.sv
// rtl/rand_range_width_lut.sv - combinational limit to right-shift amount (8 - w)
module rand_width_lut
  import rand_pkg::*;
(
  input  logic [RND_W-1:0] limit,
  output logic [3:0]       shift
);

  // Shift that keeps only the w high-order bits of the random word
  always_comb begin
    shift = 4'(RND_W) - limit_to_width(limit);
  end

endmodule

// File: rtl/rand_range.sv
// rtl/rand_range.sv - bounded rejection sampler mapping random bytes to [0, limit); optional RAND_RANGE_STATS_EN counters
module rand_range
  import rand_pkg::*;
#(
  parameter int MAX_TRIES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RND_W-1:0] rnd_in,
  rand_range_if.slave      bus
`ifdef RAND_RANGE_STATS_EN
  ,
  output logic [15:0]      reject_count,
  output logic [15:0]      fallback_count
`endif
);

  localparam logic [3:0] TRIES_LAST = 4'(MAX_TRIES - 1);

  state_t           state_q, state_d;
  logic [RND_W-1:0] limit_q, limit_d;
  logic [RND_W-1:0] value_q, value_d;
  logic [3:0]       shift_q, shift_d;
  logic [3:0]       tries_q, tries_d;
  logic             fb_q, fb_d;
  logic [3:0]       lut_shift;
  logic [RND_W-1:0] cand;
  logic [RND_W:0]   limit_ext;
  logic             cand_ok;
  logic             tries_last;

  rand_width_lut u_lut (
    .limit (bus.req_limit),
    .shift (lut_shift)
  );

  // High-order bits only: the low bits of a power-of-two LCG have short periods
  assign cand       = rnd_in >> shift_q;
  assign limit_ext  = (limit_q == '0) ? {1'b1, {RND_W{1'b0}}} : {1'b0, limit_q};
  assign cand_ok    = {1'b0, cand} < limit_ext;
  assign tries_last = (tries_q == TRIES_LAST);

  assign bus.req_ready    = (state_q == IDLE) && !rst;
  assign bus.rsp_valid    = (state_q == DONE);
  assign bus.rsp_value    = value_q;
  assign bus.rsp_fallback = fb_q;

  // Next-state and datapath updates for IDLE -> SAMPLE -> DONE
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    shift_d = shift_q;
    tries_d = tries_q;
    value_d = value_q;
    fb_d    = fb_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          limit_d = bus.req_limit;
          shift_d = lut_shift;
          tries_d = 4'd0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (cand_ok) begin
          value_d = cand;
          fb_d    = 1'b0;
          state_d = DONE;
        end else if (tries_last) begin
          // 2^w < 2*limit, so the wrapped candidate is always in range
          value_d = cand - limit_q;
          fb_d    = 1'b1;
          state_d = DONE;
        end else begin
          tries_d = tries_q + 4'd1;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      limit_q <= '0;
      shift_q <= 4'd0;
      tries_q <= 4'd0;
      value_q <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      limit_q <= limit_d;
      shift_q <= shift_d;
      tries_q <= tries_d;
      value_q <= value_d;
      fb_q    <= fb_d;
    end
  end

`ifdef RAND_RANGE_STATS_EN
  logic sample_reject;
  logic sample_fallback;

  assign sample_reject   = (state_q == SAMPLE) && !cand_ok && !tries_last;
  assign sample_fallback = (state_q == SAMPLE) && !cand_ok && tries_last;

  // Saturating reject / fallback event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reject_count   <= 16'd0;
      fallback_count <= 16'd0;
    end else begin
      if (sample_reject && reject_count != 16'hFFFF) reject_count <= reject_count + 16'd1;
      if (sample_fallback && fallback_count != 16'hFFFF) fallback_count <= fallback_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rand_range.sv
// tb/tb_rand_range.sv - scoreboard bench for rand_range with directed vectors
module tb_rand_range;
  import rand_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rnd_in = 8'h00;

  rand_range_if bus ();

`ifdef RAND_RANGE_STATS_EN
  logic [15:0] reject_count;
  logic [15:0] fallback_count;
`endif

  rand_range #(.MAX_TRIES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rnd_in         (rnd_in),
    .bus            (bus)
`ifdef RAND_RANGE_STATS_EN
    ,
    .reject_count   (reject_count),
    .fallback_count (fallback_count)
`endif
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] expq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected response on every completed response handshake
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = expq.pop_front();
        check("rsp_value", 32'(bus.rsp_value), 32'(e[7:0]));
        check("rsp_fallback", 32'(bus.rsp_fallback), 32'(e[8]));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic do_req(input logic [7:0] lim, input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] exp_val, input logic exp_fb, input int exp_lat,
                        input string name);
    int lat = 0;
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_limit = lim;
    rnd_in        = r0;
    expq.push_back({exp_fb, exp_val});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (bus.rsp_valid) break;
      rnd_in = r1;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = 1'b0;
    bus.req_limit = 8'h00;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_value", 32'(bus.rsp_value), 32'd0);
    check("rst_rsp_fallback", 32'(bus.rsp_fallback), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    do_req(8'd6,   8'hA0, 8'hA0, 8'd5,   1'b0, 1, "simple");
    do_req(8'd6,   8'hE0, 8'h40, 8'd2,   1'b0, 2, "reject_accept");
`ifdef RAND_RANGE_STATS_EN
    check("stats_rej_a", 32'(reject_count), 32'd1);
    check("stats_fb_a", 32'(fallback_count), 32'd0);
`endif
    do_req(8'd5,   8'hFF, 8'hFF, 8'd2,   1'b1, 4, "fallback5");
`ifdef RAND_RANGE_STATS_EN
    check("stats_rej_b", 32'(reject_count), 32'd4);
    check("stats_fb_b", 32'(fallback_count), 32'd1);
`endif
    do_req(8'd1,   8'h77, 8'h77, 8'd0,   1'b0, 1, "limit1");
    do_req(8'd0,   8'hC3, 8'hC3, 8'hC3,  1'b0, 1, "limit0");
    do_req(8'd200, 8'hC7, 8'hC7, 8'd199, 1'b0, 1, "limit200_hi");
    do_req(8'd200, 8'hC8, 8'h10, 8'd16,  1'b0, 2, "limit200_rej");
    do_req(8'd128, 8'hFF, 8'hFF, 8'd127, 1'b0, 1, "limit128");
    do_req(8'd3,   8'hC0, 8'hC0, 8'd0,   1'b1, 4, "fallback3");
    do_req(8'd2,   8'h80, 8'h80, 8'd1,   1'b0, 1, "limit2");
    do_req(8'd255, 8'hFF, 8'hFE, 8'd254, 1'b0, 2, "limit255");
`ifdef RAND_RANGE_STATS_EN
    check("stats_rej_c", 32'(reject_count), 32'd9);
    check("stats_fb_c", 32'(fallback_count), 32'd2);
`endif

    // Backpressure: response held while rnd_in and req_valid wiggle
    wait_ready();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_limit = 8'd6;
    rnd_in        = 8'hA0;
    expq.push_back({1'b0, 8'd5});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_latency", 32'(n), 32'd1);
    for (int i = 0; i < 5; i++) begin
      rnd_in        = 8'(i * 37 + 1);
      bus.req_valid = 1'b1;
      bus.req_limit = 8'd0;
      @(posedge clk); #1;
      check("bp_value", 32'(bus.rsp_value), 32'd5);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    check("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Async reset in the middle of SAMPLE: request dropped, outputs cleared at once
    bus.req_valid = 1'b1;
    bus.req_limit = 8'd3;
    rnd_in        = 8'hC0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_req_ready", 32'(bus.req_ready), 32'd0);
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_rsp_value", 32'(bus.rsp_value), 32'd0);
    check("arst_rsp_fallback", 32'(bus.rsp_fallback), 32'd0);
`ifdef RAND_RANGE_STATS_EN
    check("arst_stats_rej", 32'(reject_count), 32'd0);
    check("arst_stats_fb", 32'(fallback_count), 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_release_req_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("arst_no_stale_valid", 32'(bus.rsp_valid), 32'd0);
    end

    do_req(8'd6, 8'hA0, 8'hA0, 8'd5, 1'b0, 1, "after_reset");

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(expq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
